// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared FSM state and result encodings for the sequential magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_EQ = 2'b00;

endpackage

// File: rtl/cmp_chunk.sv
// rtl/cmp_chunk.sv - combinational unsigned compare of one CHUNK-bit operand slice
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    // Plain unsigned relation; signedness is folded in upstream via offset binary
    always_comb begin
        gt_o = (a_i > b_i);
        lt_o = (a_i < b_i);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - MSB-first multi-cycle magnitude compare, min/max outputs under CMP_MINMAX_EN
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       cmp_o,
    output logic             eq_o
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int LAST   = NCHUNK - 1;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("seq_magnitude_comparator: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    cmp_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [1:0]       cmp_q, cmp_d;
    logic             eq_q, eq_d;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
`endif

    logic [WIDTH-1:0] a_ob, b_ob;
    logic [CHUNK-1:0] a_sl, b_sl;
    int               sh_amt;
    logic             sl_gt, sl_lt;

    // Offset-binary view: flipping the sign bit turns a signed compare into an unsigned one
    always_comb begin
        a_ob   = a_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
        b_ob   = b_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
        sh_amt = (LAST - int'(idx_q)) * CHUNK;
        a_sl   = CHUNK'(a_ob >> sh_amt);
        b_sl   = CHUNK'(b_ob >> sh_amt);
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i  (a_sl),
        .b_i  (b_sl),
        .gt_o (sl_gt),
        .lt_o (sl_lt)
    );

    // Next-state and result logic; results are only rewritten on the CMP -> DONE step
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        cmp_d   = cmp_q;
        eq_d    = eq_q;
`ifdef CMP_MINMAX_EN
        min_d   = min_q;
        max_d   = max_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sgn_d   = signed_i;
                    idx_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (sl_gt || sl_lt) begin
                    cmp_d   = sl_gt ? CMP_GT : CMP_LT;
                    eq_d    = 1'b0;
                    state_d = DONE;
`ifdef CMP_MINMAX_EN
                    min_d   = sl_gt ? b_q : a_q;
                    max_d   = sl_gt ? a_q : b_q;
`endif
                end else if (idx_q == IDX_W'(LAST)) begin
                    cmp_d   = CMP_EQ;
                    eq_d    = 1'b1;
                    state_d = DONE;
`ifdef CMP_MINMAX_EN
                    min_d   = a_q;
                    max_d   = a_q;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            cmp_q   <= CMP_EQ;
            eq_q    <= 1'b0;
`ifdef CMP_MINMAX_EN
            min_q   <= '0;
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            cmp_q   <= cmp_d;
            eq_q    <= eq_d;
`ifdef CMP_MINMAX_EN
            min_q   <= min_d;
            max_q   <= max_d;
`endif
        end
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        cmp_o     = cmp_q;
        eq_o      = eq_q;
`ifdef CMP_MINMAX_EN
        min_o     = min_q;
        max_o     = max_q;
`endif
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - randomized self-checking bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        signed_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  cmp_o;
    logic        eq_o;
`ifdef CMP_MINMAX_EN
    logic [15:0] min_o, max_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .signed_i  (signed_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cmp_o     (cmp_o),
        .eq_o      (eq_o)
`ifdef CMP_MINMAX_EN
        ,
        .min_o     (min_o),
        .max_o     (max_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: relation from plain integer arithmetic, latency from the most significant differing bit
    function automatic logic [1:0] ref_cmp(input logic [15:0] a, input logic [15:0] b, input logic s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        if (ia > ib) return 2'b10;
        if (ia < ib) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a ^ b;
        if (d == 16'h0) return 4;
        for (int p = 15; p >= 0; p--)
            if (d[p]) return (15 - p) / 4 + 1;
        return 4;
    endfunction

    task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
        int         lat;
        logic [1:0] exp_c;
        exp_c = ref_cmp(a, b, s);
        @(negedge clk);
        check("ready_idle", 32'(in_ready), 32'd1);
        a_i = a; b_i = b; signed_i = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_lat(a, b)));
        check("cmp", 32'(cmp_o), 32'(exp_c));
        check("eq", 32'(eq_o), 32'(exp_c == 2'b00));
        check("ready_done", 32'(in_ready), 32'd0);
`ifdef CMP_MINMAX_EN
        check("min", 32'(min_o), 32'((exp_c == 2'b10) ? b : a));
        check("max", 32'(max_o), 32'((exp_c == 2'b01) ? b : a));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            a_i = 16'($urandom); b_i = 16'($urandom); signed_i = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_cmp", 32'(cmp_o), 32'(exp_c));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cmp", 32'(cmp_o), 32'd0);
        check("rst_eq", 32'(eq_o), 32'd0);
`ifdef CMP_MINMAX_EN
        check("rst_min", 32'(min_o), 32'd0);
        check("rst_max", 32'(max_o), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        do_txn(16'h1234, 16'h1234, 1'b0, 0);
        do_txn(16'h8000, 16'h7FFF, 1'b0, 0);
        do_txn(16'h8000, 16'h7FFF, 1'b1, 0);
        do_txn(16'h1235, 16'h1234, 1'b0, 0);
        do_txn(16'h0234, 16'h1234, 1'b0, 0);
        do_txn(16'h1235, 16'h1234, 1'b0, 5);
        do_txn(16'hFFFF, 16'h0001, 1'b1, 1);
        do_txn(16'hFFFF, 16'h0001, 1'b0, 0);

        // Reset mid-compare must drop the transaction
        @(negedge clk);
        a_i = 16'h1235; b_i = 16'h1234; signed_i = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cmp", 32'(cmp_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_noresult", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            do_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
